// File: rtl/kldiv_pkg.sv
// rtl/kldiv_pkg.sv - shared defaults, FSM state type and accumulator sizing helper for the KL batchmean reducer
package kldiv_pkg;

  localparam int KLDIV_DATA_W = 32;
  localparam int KLDIV_FRAC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } kldiv_red_state_t;

  // Smallest accumulator that can hold a full batch of worst-case terms without wrapping.
  function automatic int kldiv_min_acc_w(input int data_w, input int elems_per_row, input int batch_log2);
    return data_w + $clog2(elems_per_row) + batch_log2;
  endfunction

endpackage

// File: rtl/kldiv_round_sat.sv
// rtl/kldiv_round_sat.sv - combinational round-half-up, arithmetic shift and optional clamp (KLDIV_RED_SAT_EN)
module kldiv_round_sat #(
  parameter int ACC_W      = 64,
  parameter int DATA_W     = 32,
  parameter int BATCH_LOG2 = 7
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  // One guard bit keeps the rounding add from wrapping at the top of the accumulator range.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (BATCH_LOG2 - 1);

  logic [ACC_W:0]        rounded;
  logic signed [ACC_W:0] shifted;

  assign rounded = {acc[ACC_W-1], acc} + HALF;
  assign shifted = $signed(rounded) >>> BATCH_LOG2;

`ifdef KLDIV_RED_SAT_EN
  logic [ACC_W-DATA_W+1:0] top_bits;
  logic                    fits;

  // The shifted sum fits when every bit above the result sign bit matches it.
  assign top_bits = shifted[ACC_W:DATA_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  // Clamp toward the bound on the side of the true sign.
  always_comb begin
    result = shifted[DATA_W-1:0];
    sat    = 1'b0;
    if (!fits) begin
      sat    = 1'b1;
      result = shifted[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_high_bits;

  // Without clamping the result simply wraps to the low DATA_W bits.
  assign result           = shifted[DATA_W-1:0];
  assign sat              = 1'b0;
  assign unused_high_bits = ^shifted[ACC_W:DATA_W];
`endif

endmodule

// File: rtl/kldiv_batchmean_reducer.sv
// rtl/kldiv_batchmean_reducer.sv - sums one batch of KL terms, divides by batch size, holds the scalar loss (KLDIV_RED_SAT_EN enables clamping)
module kldiv_batchmean_reducer
  import kldiv_pkg::*;
#(
  parameter int DATA_W        = KLDIV_DATA_W,
  parameter int FRAC_W        = KLDIV_FRAC_W,
  parameter int ELEMS_PER_ROW = 4096,
  parameter int BATCH_LOG2    = 7,
  parameter int ACC_W         = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [DATA_W-1:0] output_data,
  output logic              sat_out
);

  localparam int TOTAL = ELEMS_PER_ROW << BATCH_LOG2;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  // The binary point is carried implicitly; the arithmetic is scale-free.
  localparam int unused_frac_w = FRAC_W;

  kldiv_red_state_t  state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [ACC_W-1:0]  term_ext;
  logic [DATA_W-1:0] rs_result;
  logic              rs_sat;
  logic              xfer;

  assign term_ext = {{(ACC_W-DATA_W){input_data[DATA_W-1]}}, input_data};
  assign xfer     = valid_in && in_ready;

  kldiv_round_sat #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .BATCH_LOG2 (BATCH_LOG2)
  ) u_round_sat (
    .acc    (acc),
    .result (rs_result),
    .sat    (rs_sat)
  );

  // Batch FSM: accumulate TOTAL terms, latch the rounded mean, hold it until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      in_ready    <= 1'b0;
      valid_out   <= 1'b0;
      output_data <= '0;
      sat_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
        ACCUM: begin
          if (xfer) begin
            acc <= acc + term_ext;
            if (count == LAST) begin
              state    <= FINAL;
              in_ready <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FINAL: begin
          output_data <= rs_result;
          sat_out     <= rs_sat;
          valid_out   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            valid_out <= 1'b0;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kldiv_batchmean_reducer.sv
// tb/tb_kldiv_batchmean_reducer.sv - self-checking bench for kldiv_batchmean_reducer with a small arithmetic reference model
module tb_kldiv_batchmean_reducer;

  localparam int EPR   = 4;
  localparam int BL2   = 1;
  localparam int TOTAL = EPR << BL2;

  typedef logic [31:0] batch_t [TOTAL];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        in_ready;
  logic [31:0] input_data = '0;
  logic        valid_out;
  logic        out_ready = 1'b0;
  logic [31:0] output_data;
  logic        sat_out;

  int tests_run = 0;
  int fails     = 0;

  kldiv_batchmean_reducer #(
    .DATA_W        (32),
    .FRAC_W        (16),
    .ELEMS_PER_ROW (EPR),
    .BATCH_LOG2    (BL2),
    .ACC_W         (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .input_data  (input_data),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .output_data (output_data),
    .sat_out     (sat_out)
  );

  always #5 clk = ~clk;

  // Reference: exact integer mean with round-half-up via floor division, then clamp or wrap.
  function automatic void model(input batch_t t, output logic [31:0] d, output logic s);
    longint sum, q, dv, maxv, minv;
    sum  = 0;
    for (int i = 0; i < TOTAL; i++) sum += longint'($signed(t[i]));
    dv   = longint'(1) <<< BL2;
    sum  = sum + dv / 2;
    q    = sum / dv;
    if ((sum % dv != 0) && (sum < 0)) q = q - 1;
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    s = 1'b0;
    d = q[31:0];
`ifdef KLDIV_RED_SAT_EN
    if (q > maxv) begin d = 32'h7FFF_FFFF; s = 1'b1; end
    else if (q < minv) begin d = 32'h8000_0000; s = 1'b1; end
`else
    if (q > maxv || q < minv) s = 1'b0;
`endif
  endfunction

  function automatic batch_t fill(input logic [31:0] v);
    batch_t t;
    for (int i = 0; i < TOTAL; i++) t[i] = v;
    return t;
  endfunction

  // Offers the batch, returns right after the edge that accepted the last term; valid_in stays as left.
  task automatic drive_batch(input batch_t t, input int gap_pct, output bit timeout, output int accepted);
    int guard;
    bit will_xfer;
    accepted = 0;
    guard    = 0;
    timeout  = 1'b0;
    while (accepted < TOTAL && guard < 500) begin
      @(negedge clk);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        valid_in   = 1'b0;
        input_data = $urandom;
      end else begin
        valid_in   = 1'b1;
        input_data = t[accepted];
      end
      will_xfer = valid_in && in_ready;
      @(posedge clk);
      if (will_xfer) accepted++;
      guard++;
    end
    if (accepted < TOTAL) timeout = 1'b1;
  endtask

  // Waits for a result, captures it and completes the output handshake.
  task automatic take_result(output logic [31:0] d, output logic s, output bit timeout);
    int guard;
    guard   = 0;
    timeout = 1'b0;
    @(negedge clk);
    while (!valid_out && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!valid_out) timeout = 1'b1;
    d = output_data;
    s = sat_out;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({in_ready, valid_out, sat_out, output_data} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sat=%b data=%h, want all 0", in_ready, valid_out, sat_out, output_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready_rise: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_latency;
    bit to; int acc_n;
    drive_batch(fill(32'h0001_0000), 0, to, acc_n);
    tests_run++;
    if (to) begin fails++; $display("FAIL basic_feed_timeout: accepted %0d want %0d", acc_n, TOTAL); end
    @(negedge clk);
    valid_in = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_final_cycle: got vld=%b rdy=%b want 0 0", valid_out, in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (valid_out !== 1'b1) begin fails++; $display("FAIL basic_latency: valid_out=%b want 1", valid_out); end
    tests_run++;
    if (output_data !== 32'h0004_0000 || sat_out !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: got %h sat=%b want 00040000 sat=0", output_data, sat_out);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_rounding;
    batch_t t; bit to, to2; int acc_n; logic [31:0] d; logic s;
    logic [31:0] odd [2];
    logic [31:0] want [2];
    odd[0] = 32'h0000_0001; want[0] = 32'h0000_0001;
    odd[1] = 32'hFFFF_FFFF; want[1] = 32'h0000_0000;
    for (int k = 0; k < 2; k++) begin
      t = fill(32'h0);
      t[TOTAL-1] = odd[k];
      drive_batch(t, 0, to, acc_n);
      @(negedge clk);
      valid_in = 1'b0;
      take_result(d, s, to2);
      tests_run++;
      if (to || to2 || d !== want[k] || s !== 1'b0) begin
        fails++;
        $display("FAIL rounding_%0d: got %h sat=%b want %h sat=0", k, d, s, want[k]);
      end
    end
  endtask

  task automatic test_saturation;
    bit to, to2; int acc_n; logic [31:0] d, md; logic s, ms;
    drive_batch(fill(32'h7FFF_FFFF), 0, to, acc_n);
    @(negedge clk);
    valid_in = 1'b0;
    take_result(d, s, to2);
    model(fill(32'h7FFF_FFFF), md, ms);
    tests_run++;
`ifdef KLDIV_RED_SAT_EN
    if (to || to2 || d !== 32'h7FFF_FFFF || s !== 1'b1) begin
      fails++;
      $display("FAIL sat_max: got %h sat=%b want 7fffffff sat=1", d, s);
    end
`else
    if (to || to2 || d !== 32'hFFFF_FFFC || s !== 1'b0) begin
      fails++;
      $display("FAIL wrap_max: got %h sat=%b want fffffffc sat=0", d, s);
    end
`endif
    tests_run++;
    if (d !== md || s !== ms) begin
      fails++;
      $display("FAIL sat_model: got %h sat=%b model %h sat=%b", d, s, md, ms);
    end
  endtask

  task automatic test_backpressure;
    bit to, to2; int acc_n; logic [31:0] held, d; logic s;
    drive_batch(fill(32'h0001_0000), 0, to, acc_n);
    @(negedge clk);
    input_data = $urandom;
    @(negedge clk);
    held = output_data;
    for (int c = 0; c < 5; c++) begin
      valid_in   = 1'b1;
      input_data = $urandom;
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b1 || in_ready !== 1'b0 || output_data !== held || held !== 32'h0004_0000) begin
        fails++;
        $display("FAIL hold_cycle_%0d: vld=%b rdy=%b data=%h want 1 0 00040000", c, valid_out, in_ready, output_data);
      end
    end
    valid_in  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: vld=%b rdy=%b want 0 1", valid_out, in_ready);
    end
    drive_batch(fill(32'h0001_0000), 0, to, acc_n);
    @(negedge clk);
    valid_in = 1'b0;
    take_result(d, s, to2);
    tests_run++;
    if (to || to2 || d !== 32'h0004_0000 || s !== 1'b0) begin
      fails++;
      $display("FAIL hold_next_batch: got %h sat=%b want 00040000 sat=0", d, s);
    end
  endtask

  task automatic test_gaps;
    bit to, to2; int acc_n; logic [31:0] d; logic s;
    drive_batch(fill(32'h0001_0000), 40, to, acc_n);
    @(negedge clk);
    valid_in = 1'b0;
    take_result(d, s, to2);
    tests_run++;
    if (to || to2 || acc_n !== TOTAL || d !== 32'h0004_0000 || s !== 1'b0) begin
      fails++;
      $display("FAIL gaps_result: got %h sat=%b count=%0d want 00040000 sat=0 count=%0d", d, s, acc_n, TOTAL);
    end
  endtask

  task automatic test_random;
    batch_t t; bit to, to2; int acc_n; logic [31:0] d, md; logic s, ms;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < TOTAL; i++) begin
        if (n < 3) t[i] = 32'($signed($urandom_range(2000000)) - 1000000);
        else t[i] = (n == 5) ? (32'h8000_0000 | ($urandom & 32'h00FF_FFFF)) : $urandom;
      end
      drive_batch(t, 25, to, acc_n);
      @(negedge clk);
      valid_in = 1'b0;
      take_result(d, s, to2);
      model(t, md, ms);
      tests_run++;
      if (to || to2 || d !== md || s !== ms) begin
        fails++;
        $display("FAIL random_%0d: got %h sat=%b model %h sat=%b", n, d, s, md, ms);
      end
    end
  endtask

  task automatic test_mid_reset;
    bit to, to2; int acc_n; logic [31:0] d; logic s;
    batch_t three;
    three = fill(32'h0123_4567);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in   = 1'b1;
      input_data = three[i];
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_during: vld=%b rdy=%b want 0 0", valid_out, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    drive_batch(fill(32'h0001_0000), 0, to, acc_n);
    @(negedge clk);
    valid_in = 1'b0;
    take_result(d, s, to2);
    tests_run++;
    if (to || to2 || d !== 32'h0004_0000 || s !== 1'b0) begin
      fails++;
      $display("FAIL midreset_result: got %h sat=%b want 00040000 sat=0", d, s);
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/kldiv_batchmean_reducer.md
# kldiv_batchmean_reducer

Consumer end of the KL-divergence stream. Accepts per-element KL terms (signed fixed-point) from the element-wise KL divergence stage and sums them over a full batch. It then divides by the batch size ("batchmean" reduction) and presents one scalar loss with ready/valid backpressure. Sits directly downstream of the element-wise KL divergence unit, feeding the loss writeback path.

## Interface
- DATA_W, 32, width of input terms and result (signed two's complement)
- FRAC_W, 16, fractional bits of input and result (Q16.16); pass-through only, not used in arithmetic
- ELEMS_PER_ROW, 4096, terms per distribution row
- BATCH_LOG2, 7, log2 of batch size (rows per result); must be ≥1
- ACC_W, 64, accumulator width; must be ≥ DATA_W + clog2(ELEMS_PER_ROW) + BATCH_LOG2

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  input term valid
- in_ready  out  1  block can accept a term
- input_data  in  DATA_W  per-element KL term
- valid_out  out  1  result valid
- out_ready  in  1  downstream accepts result
- output_data  out  DATA_W  batchmean loss
- sat_out  out  1  result was saturated; qualified by valid_out

## Operation
- Input transfer when valid_in && in_ready. output_data transfer when valid_out && out_ready. input_data is ignored when no transfer occurs.
- TOTAL = ELEMS_PER_ROW << BATCH_LOG2 terms per result; a counter tracks accepted terms.
- States:
  - IDLE: entered on reset; goes to ACCUM unconditionally next cycle.
  - ACCUM: in_ready=1; each transfer adds the sign-extended term to acc. On the transfer with count==TOTAL-1, go to FINAL.
  - FINAL: in_ready=0; compute the result, register output_data and sat_out, go to HOLD.
  - HOLD: valid_out=1; on out_ready, clear acc and count, go to ACCUM.
- Result = (acc + 2^(BATCH_LOG2-1)) >>> BATCH_LOG2, i.e. round half toward +inf, followed by saturation to signed DATA_W.
- Accumulator never wraps for legal parameters; no overflow check on acc.
- in_ready is low in IDLE, FINAL and HOLD. Inputs offered there are not consumed.
- Reset mid-operation: acc, count and the partial result are discarded. No partial result is emitted.

## Timing
- Reset values:
  - in_ready=0
  - valid_out=0
  - output_data=0
  - sat_out=0
  - state IDLE, acc=0, count=0
- in_ready rises in the first cycle after rst_n deasserts (IDLE→ACCUM).
- Throughput: one term per cycle in ACCUM.
- Latency: the final input transfer at edge k gives valid_out=1 and a stable result after edge k+1.
- valid_out, output_data and sat_out are held stable until the output handshake.
- Output handshake at edge m: valid_out=0 and in_ready=1 after edge m. Minimum dead time between batches is 2 cycles (FINAL, HOLD).
- in_ready, valid_out and sat_out are decoded from registered state, with no combinational input→output path.

## Configuration
- KLDIV_RED_SAT_EN defined: results outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] clamp to the nearest bound, and sat_out=1 with that result.
- KLDIV_RED_SAT_EN undefined: output_data is the low DATA_W bits of the shifted sum (wraps), and sat_out is tied 0.

## Structure
- Package kldiv_pkg holds:
  - DATA_W and FRAC_W defaults
  - the state enum kldiv_red_state_t (IDLE, ACCUM, FINAL, HOLD)
  - a function computing the minimum legal ACC_W
- One sub-module: kldiv_round_sat. It is purely combinational and performs round, arithmetic shift and optional saturation, taking ACC_W in and producing DATA_W out plus a sat flag. The top instantiates it once and registers its outputs in FINAL.

## Test plan
Bench parameters: ELEMS_PER_ROW=4, BATCH_LOG2=1, so TOTAL=8.
- Eight terms 0x0001_0000 back-to-back → output_data=0x0004_0000, sat_out=0, valid_out exactly one cycle after the 8th transfer edge.
- Seven terms 0 plus one 0x0000_0001 → 0x0000_0001. Repeat with 0xFFFF_FFFF in place of 0x0000_0001 → 0x0000_0000, confirming round half toward +inf.
- Eight terms 0x7FFF_FFFF:
  - With KLDIV_RED_SAT_EN → 0x7FFF_FFFF, sat_out=1.
  - Without KLDIV_RED_SAT_EN → 0xFFFF_FFFC, sat_out=0.
- Result pending with out_ready held low for 5 cycles while valid_in=1 → output_data stable, in_ready=0, no terms consumed. After release: handshake, then in_ready=1 the next cycle, and the next batch of eight 0x0001_0000 → 0x0004_0000 again, confirming acc was cleared.
- Case 1 repeated with random valid_in gaps → identical result and count.
- rst_n pulsed low after 3 accepted terms:
  - During reset: valid_out=0 and in_ready=0.
  - One cycle after release: in_ready=1.
  - Eight fresh terms 0x0001_0000 → 0x0004_0000, proving the earlier 3 terms were discarded.
